// File: rtl/grid_wb_ctrl.sv
// RCA grid writeback sequencer: latches one op's port routing,
// waits for its IO units, then hands results to the writeback stage.
module grid_wb_ctrl #(
    parameter int XLEN           = 32,
    parameter int NUM_ROWS       = 8,
    parameter int NUM_PORTS      = 2,
    parameter int ID_W           = 3,
    parameter int TIMEOUT_CYCLES = 255,
    localparam int SEL_W = $clog2(NUM_ROWS)
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                flush,
    input  logic                                issue_valid,
    output logic                                issue_ready,
    input  logic [NUM_PORTS-1:0][SEL_W-1:0]     issue_sels,
    input  logic [NUM_PORTS-1:0][4:0]           issue_rd,
    input  logic [NUM_PORTS-1:0]                issue_we,
    input  logic [ID_W-1:0]                     issue_id,
    input  logic [NUM_ROWS-1:0][XLEN-1:0]       io_unit_data,
    input  logic [NUM_ROWS-1:0]                 io_unit_data_valid,
    output logic [NUM_PORTS-1:0][SEL_W-1:0]     io_unit_sels,
    output logic                                io_unit_sels_valid,
    output logic                                wb_valid,
    input  logic                                wb_ack,
    output logic [NUM_PORTS-1:0][XLEN-1:0]      wb_data,
    output logic [NUM_PORTS-1:0][4:0]           wb_rd,
    output logic [NUM_PORTS-1:0]                wb_we,
    output logic [ID_W-1:0]                     wb_id,
    output logic                                busy,
    output logic                                timeout_err
);

    localparam int CNT_W =
        (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int LAST_I =
        (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam logic [CNT_W-1:0] LAST = LAST_I[CNT_W-1:0];
    localparam bit TO_EN = (TIMEOUT_CYCLES > 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        WB   = 2'd2
    } state_t;

    state_t                             state;
    logic [CNT_W-1:0]                   cnt;
    logic                               ready;
    logic [SEL_W-1:0]                   base_sel;
    logic                               base_found;
    logic [NUM_PORTS-1:0][SEL_W-1:0]    fill_sels;
    logic [NUM_PORTS-1:0][XLEN-1:0]     cap_data;

    assign issue_ready = (state == IDLE) & ~flush & ~rst;
    assign busy        = (state != IDLE);

    // Disabled ports follow the lowest enabled port's row (or row 0).
    always_comb begin
        base_sel   = '0;
        base_found = 1'b0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (issue_we[p] && !base_found) begin
                base_sel   = issue_sels[p];
                base_found = 1'b1;
            end
        end
        for (int p = 0; p < NUM_PORTS; p++) begin
            fill_sels[p] = issue_we[p] ? issue_sels[p] : base_sel;
        end
    end

    // All enabled ports see valid data; masked-off data reads as zero.
    always_comb begin
        ready    = 1'b1;
        cap_data = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (wb_we[p]) begin
                if (!io_unit_data_valid[io_unit_sels[p]]) begin
                    ready = 1'b0;
                end
                cap_data[p] = io_unit_data[io_unit_sels[p]];
            end
        end
    end

    // Controller FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= IDLE;
            cnt                <= '0;
            io_unit_sels       <= '0;
            io_unit_sels_valid <= 1'b0;
            wb_valid           <= 1'b0;
            wb_data            <= '0;
            wb_rd              <= '0;
            wb_we              <= '0;
            wb_id              <= '0;
            timeout_err        <= 1'b0;
        end else if (flush) begin
            state              <= IDLE;
            cnt                <= '0;
            io_unit_sels_valid <= 1'b0;
            wb_valid           <= 1'b0;
            timeout_err        <= 1'b0;
        end else begin
            timeout_err <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (issue_valid) begin
                        state              <= WAIT;
                        cnt                <= '0;
                        io_unit_sels       <= fill_sels;
                        io_unit_sels_valid <= 1'b1;
                        wb_rd              <= issue_rd;
                        wb_we              <= issue_we;
                        wb_id              <= issue_id;
                    end
                end
                WAIT: begin
                    if (ready) begin
                        state              <= WB;
                        wb_data            <= cap_data;
                        wb_valid           <= 1'b1;
                        io_unit_sels_valid <= 1'b0;
                    end else if (TO_EN && cnt == LAST) begin
                        state              <= IDLE;
                        io_unit_sels_valid <= 1'b0;
                        timeout_err        <= 1'b1;
                    end else if (cnt != '1) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WB: begin
                    if (wb_ack) begin
                        state    <= IDLE;
                        wb_valid <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_grid_wb_ctrl.sv
// Scoreboard bench for grid_wb_ctrl: driver pushes predicted
// results, a negedge monitor pops them on each DUT completion.
module tb_grid_wb_ctrl;

    localparam int XLEN = 32;
    localparam int ROWS = 8;
    localparam int NP   = 2;
    localparam int IDW  = 3;
    localparam int TO   = 4;
    localparam int SW   = 3;

    logic clk = 1'b0;
    logic rst, flush, issue_valid, issue_ready;
    logic [NP-1:0][SW-1:0]     issue_sels, io_unit_sels;
    logic [NP-1:0][4:0]        issue_rd, wb_rd;
    logic [NP-1:0]             issue_we, wb_we;
    logic [IDW-1:0]            issue_id, wb_id;
    logic [ROWS-1:0][XLEN-1:0] io_unit_data;
    logic [ROWS-1:0]           io_unit_data_valid;
    logic io_unit_sels_valid, wb_valid, wb_ack, busy, timeout_err;
    logic [NP-1:0][XLEN-1:0]   wb_data;

    grid_wb_ctrl #(
        .XLEN(XLEN), .NUM_ROWS(ROWS), .NUM_PORTS(NP),
        .ID_W(IDW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_sels(issue_sels), .issue_rd(issue_rd),
        .issue_we(issue_we), .issue_id(issue_id),
        .io_unit_data(io_unit_data),
        .io_unit_data_valid(io_unit_data_valid),
        .io_unit_sels(io_unit_sels),
        .io_unit_sels_valid(io_unit_sels_valid),
        .wb_valid(wb_valid), .wb_ack(wb_ack),
        .wb_data(wb_data), .wb_rd(wb_rd), .wb_we(wb_we),
        .wb_id(wb_id), .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit                      to;
        logic [NP-1:0][XLEN-1:0] data;
        logic [NP-1:0][4:0]      rd;
        logic [NP-1:0]           we;
        logic [IDW-1:0]          id;
    } exp_t;

    typedef int vd_t [ROWS];
    typedef logic [XLEN-1:0] rows_t [ROWS];

    exp_t q[$];
    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, got, want);
        end
    endtask

    // Monitor: every completion or timeout must match the queue head.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && (timeout_err || (wb_valid && wb_ack))) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_out got=id%0h want=none",
                         wb_id);
            end else begin
                e = q.pop_front();
                chk("kind_timeout", 64'(timeout_err), 64'(e.to));
                chk("wb_id", 64'(wb_id), 64'(e.id));
                if (e.to) begin
                    chk("to_busy", 64'(busy), 64'd0);
                    chk("to_wb_valid", 64'(wb_valid), 64'd0);
                end else begin
                    chk("wb_data", 64'(wb_data), 64'(e.data));
                    chk("wb_rd", 64'(wb_rd), 64'(e.rd));
                    chk("wb_we", 64'(wb_we), 64'(e.we));
                end
            end
        end
    end

    // One op: issue, WAIT with scripted row validity, then WB/abort.
    // fl/rx: WAIT cycle index of flush/reset, -1 for none.
    task automatic run_op(
        input logic [NP-1:0][SW-1:0] sels,
        input logic [NP-1:0]         we,
        input logic [IDW-1:0]        id,
        input vd_t                   vd,
        input rows_t                 rdat,
        input int                    fl,
        input int                    rx,
        input int                    ackd,
        input bit                    flack
    );
        exp_t e;
        logic [NP-1:0][SW-1:0] xs;
        logic [SW-1:0] base;
        logic [31:0] rv;
        bit fnd, to, ab;
        int k, endi;

        base = '0;
        fnd  = 1'b0;
        for (int p = 0; p < NP; p++) begin
            if (we[p] && !fnd) begin
                base = sels[p];
                fnd  = 1'b1;
            end
        end
        for (int p = 0; p < NP; p++) begin
            xs[p] = we[p] ? sels[p] : base;
        end

        k = 0;
        for (int p = 0; p < NP; p++) begin
            if (we[p] && vd[sels[p]] > k) k = vd[sels[p]];
        end
        to   = (k >= TO);
        endi = to ? TO - 1 : k;
        ab   = 1'b0;
        if (fl >= 0 && fl <= endi) begin
            ab   = 1'b1;
            endi = fl;
        end
        if (rx >= 0 && rx <= endi) begin
            ab   = 1'b1;
            endi = rx;
        end

        rv          = $urandom;
        issue_valid = 1'b1;
        issue_sels  = sels;
        issue_rd    = rv[9:0];
        issue_we    = we;
        issue_id    = id;
        io_unit_data_valid = '0;
        for (int r = 0; r < ROWS; r++) io_unit_data[r] = rdat[r];

        e.to = to;
        e.id = id;
        e.rd = rv[9:0];
        e.we = we;
        for (int p = 0; p < NP; p++) begin
            e.data[p] = we[p] ? rdat[sels[p]] : '0;
        end
        if (!ab) q.push_back(e);

        @(negedge clk);
        chk("issue_ready", 64'(issue_ready), 64'd1);
        @(posedge clk);
        #1;
        issue_valid = 1'b0;

        for (int i = 0; i <= endi; i++) begin
            for (int r = 0; r < ROWS; r++) begin
                io_unit_data_valid[r] = (vd[r] <= i);
            end
            flush  = (i == fl);
            rst    = (i == rx);
            wb_ack = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (i == 0) begin
                chk("sels_valid", 64'(io_unit_sels_valid), 64'd1);
                chk("busy_wait", 64'(busy), 64'd1);
                chk("io_unit_sels", 64'(io_unit_sels), 64'(xs));
            end
            @(posedge clk);
            #1;
        end
        flush  = 1'b0;
        rst    = 1'b0;
        wb_ack = 1'b0;

        if (ab || to) begin
            @(negedge clk);
            chk("end_busy", 64'(busy), 64'd0);
            chk("end_wb_valid", 64'(wb_valid), 64'd0);
            if (rx >= 0) begin
                chk("rst_wb_id", 64'(wb_id), 64'd0);
                chk("rst_wb_we", 64'(wb_we), 64'd0);
            end
            @(posedge clk);
            #1;
        end else begin
            io_unit_data_valid = '0;
            for (int c = 0; c < ackd; c++) begin
                for (int r = 0; r < ROWS; r++) io_unit_data[r] = $urandom;
                @(negedge clk);
                chk("wb_held", 64'(wb_valid), 64'd1);
                chk("wb_data_stable", 64'(wb_data), 64'(e.data));
                @(posedge clk);
                #1;
            end
            wb_ack = 1'b1;
            flush  = flack;
            @(posedge clk);
            #1;
            wb_ack = 1'b0;
            flush  = 1'b0;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=running want=finished");
        $fatal(1);
    end

    initial begin
        vd_t   vdr;
        rows_t rows;
        logic [31:0] rv;
        int f;

        rst = 1'b1;
        flush = 1'b0;
        issue_valid = 1'b0;
        issue_sels = '0;
        issue_rd = '0;
        issue_we = '0;
        issue_id = '0;
        io_unit_data = '0;
        io_unit_data_valid = '0;
        wb_ack = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_issue_ready", 64'(issue_ready), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_wb_valid", 64'(wb_valid), 64'd0);
        chk("rst_sels_valid", 64'(io_unit_sels_valid), 64'd0);
        chk("rst_timeout", 64'(timeout_err), 64'd0);
        chk("rst_wb_data", 64'(wb_data), 64'd0);
        chk("rst_wb_id", 64'(wb_id), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Rows 3 and 5 valid four cycles after issue.
        for (int r = 0; r < ROWS; r++) begin
            vdr[r]  = 99;
            rows[r] = $urandom;
        end
        vdr[3] = 3;
        vdr[5] = 3;
        rows[3] = 32'hA;
        rows[5] = 32'hB;
        run_op({3'd5, 3'd3}, 2'b11, 3'd2, vdr, rows, -1, -1, 0, 1'b0);

        // Only port 1 enabled; row of port 0 never valid.
        for (int r = 0; r < ROWS; r++) vdr[r] = 99;
        vdr[6] = 0;
        run_op({3'd6, 3'd2}, 2'b10, 3'd4, vdr, rows, -1, -1, 1, 1'b0);

        // Timeout.
        for (int r = 0; r < ROWS; r++) vdr[r] = 99;
        run_op({3'd1, 3'd0}, 2'b01, 3'd7, vdr, rows, -1, -1, 0, 1'b0);

        // Flush in second WAIT cycle.
        for (int r = 0; r < ROWS; r++) vdr[r] = 2;
        run_op({3'd7, 3'd4}, 2'b11, 3'd1, vdr, rows, 1, -1, 0, 1'b0);

        // Flush together with issue_valid in IDLE.
        issue_valid = 1'b1;
        flush = 1'b1;
        issue_we = 2'b11;
        @(negedge clk);
        chk("flush_issue_ready", 64'(issue_ready), 64'd0);
        @(posedge clk);
        #1;
        issue_valid = 1'b0;
        flush = 1'b0;
        @(negedge clk);
        chk("flush_issue_busy", 64'(busy), 64'd0);
        chk("flush_issue_sv", 64'(io_unit_sels_valid), 64'd0);
        @(posedge clk);
        #1;

        // Ack held off for 10 cycles while row data changes.
        for (int r = 0; r < ROWS; r++) vdr[r] = 1;
        run_op({3'd0, 3'd2}, 2'b11, 3'd3, vdr, rows, -1, -1, 10, 1'b0);

        // Empty masks back to back.
        run_op({3'd1, 3'd1}, 2'b00, 3'd5, vdr, rows, -1, -1, 0, 1'b0);
        run_op({3'd2, 3'd3}, 2'b00, 3'd6, vdr, rows, -1, -1, 0, 1'b0);

        // Reset in the middle of WAIT.
        for (int r = 0; r < ROWS; r++) vdr[r] = 3;
        run_op({3'd4, 3'd5}, 2'b11, 3'd2, vdr, rows, -1, 1, 0, 1'b0);

        // Flush together with ack still completes.
        for (int r = 0; r < ROWS; r++) vdr[r] = 0;
        run_op({3'd6, 3'd7}, 2'b01, 3'd1, vdr, rows, -1, -1, 2, 1'b1);

        for (int n = 0; n < 80; n++) begin
            for (int r = 0; r < ROWS; r++) begin
                vdr[r]  = $urandom_range(0, 6);
                if (vdr[r] == 6) vdr[r] = 99;
                rows[r] = $urandom;
            end
            rv = $urandom;
            f  = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 4) : -1;
            run_op(rv[5:0], rv[7:6], rv[10:8], vdr, rows, f, -1,
                   $urandom_range(0, 3), ($urandom_range(0, 4) == 0));
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("queue_empty", 64'(q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
